// File: rtl/core_pkg.sv
// core_pkg: shared fetch FSM states, buffer geometry and bus tag constants
package core_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACTIVE, DRAIN} fetch_state_t;
  localparam int LINE_BYTES = 64;
  localparam int FETCH_BUF_BYTES = 128;
  localparam int DECODE_WINDOW_BYTES = 15;
  localparam logic READ = 1'b1;
  localparam logic [3:0] MEMORY = 4'b0001;
endpackage

// File: rtl/fetch_ring.sv
// fetch_ring: 128-byte ring with an 8-byte aligned write port and a wrapped 15-byte read window
module fetch_ring
  import core_pkg::*;
(
  input  logic                               clk,
  input  logic                               we,
  input  logic [3:0]                         wr_slot,
  input  logic [63:0]                        wr_data,
  input  logic [6:0]                         rd_idx,
  output logic [8*DECODE_WINDOW_BYTES-1:0]   window
);
  logic [7:0] mem_q [FETCH_BUF_BYTES];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 8; i++) mem_q[{wr_slot, 3'(i)}] <= wr_data[8*i +: 8];
  always_comb
    for (int i = 0; i < DECODE_WINDOW_BYTES; i++) window[8*i +: 8] = mem_q[7'(rd_idx + 7'(i))];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: line fetcher feeding a 15-byte decode window from a 128-byte ring.
// Define FETCH_TRACE_EN to print completed lines and redirects.
module fetch_unit
  import core_pkg::*;
#(
  parameter int TAG_W = 13,
  parameter logic [TAG_W-1:0] READ_TAG = TAG_W'({READ, MEMORY, 8'b0})
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       entry,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_rip,
  output logic              bus_reqcyc,
  output logic [63:0]       bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [63:0]       bus_resp,
  output logic              bus_respack,
  output logic [119:0]      decode_bytes,
  output logic [63:0]       decode_rip,
  output logic              decode_valid,
  input  logic [3:0]        decode_consume
);
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);
  fetch_state_t state_q, state_d;
  logic [7:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
  logic [63:0] line_q, line_d, req_q, req_d, rip_q, rip_d;
  logic [5:0] skip_q, skip_d;
  logic [2:0] beat_q, beat_d;
  logic reqcyc_q, reqcyc_d, beat, last, we, first;
  logic [3:0] cons;
  assign occ = wr_ptr_q - rd_ptr_q;
  assign cons = decode_valid ? decode_consume : 4'd0;
  // beats only flow once the request has been accepted; DRAIN beats are acked but never stored
  assign beat = bus_respcyc && !reqcyc_q && (state_q inside {WAIT, ACTIVE, DRAIN});
  assign last = beat && beat_q == 3'd7;
  assign we = beat && state_q != DRAIN && !redirect_valid && beat_q >= skip_q[5:3];
  assign first = we && |skip_q && beat_q == skip_q[5:3];
  always_comb begin
    state_d = state_q;
    reqcyc_d = reqcyc_q && !bus_reqack;
    req_d = req_q;
    line_d = line_q;
    skip_d = skip_q;
    beat_d = beat ? beat_q + 3'd1 : beat_q;
    wr_ptr_d = we ? wr_ptr_q + 8'd8 : wr_ptr_q;
    rd_ptr_d = first ? {5'b0, skip_q[2:0]} : rd_ptr_q + {4'b0, cons};
    rip_d = rip_q + {60'b0, cons};
    case (state_q)
      IDLE: if (!redirect_valid && occ <= 8'd64) begin
        state_d = REQ;
        reqcyc_d = 1'b1;
        req_d = line_q;
      end
      REQ: if (bus_reqack) state_d = WAIT;
      WAIT: if (beat) state_d = ACTIVE;
      ACTIVE: if (last) begin
        state_d = IDLE;
        line_d = line_q + 64'(LINE_BYTES);
        skip_d = 6'd0;
      end
      DRAIN: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // request address stays frozen in req_q so an outstanding handshake is never disturbed
    if (redirect_valid) begin
      state_d = (state_q == IDLE || last) ? IDLE : DRAIN;
      wr_ptr_d = 8'd0;
      rd_ptr_d = 8'd0;
      line_d = redirect_rip & LINE_MASK;
      rip_d = redirect_rip;
      skip_d = redirect_rip[5:0];
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= 8'd0;
      rd_ptr_q <= 8'd0;
      line_q <= entry & LINE_MASK;
      req_q <= entry & LINE_MASK;
      rip_q <= entry;
      skip_q <= entry[5:0];
      beat_q <= 3'd0;
      reqcyc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      line_q <= line_d;
      req_q <= req_d;
      rip_q <= rip_d;
      skip_q <= skip_d;
      beat_q <= beat_d;
      reqcyc_q <= reqcyc_d;
    end
  fetch_ring u_ring (
    .clk     (clk),
    .we      (we),
    .wr_slot (wr_ptr_q[6:3]),
    .wr_data (bus_resp),
    .rd_idx  (rd_ptr_q[6:0]),
    .window  (decode_bytes)
  );
  assign bus_reqcyc = reqcyc_q;
  assign bus_req = req_q;
  assign bus_reqtag = READ_TAG;
  assign bus_respack = bus_respcyc;
  assign decode_rip = rip_q;
  assign decode_valid = occ >= 8'(DECODE_WINDOW_BYTES);
  assert property (@(posedge clk) disable iff (reset) {4'b0, decode_consume} <= occ);
`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (!reset && state_q == ACTIVE && last && !redirect_valid)
      $display("[fetch] line %h done, %0d bytes written", line_q, {4'd8 - {1'b0, skip_q[5:3]}, 3'b0});
    if (!reset && redirect_valid)
      $display("[fetch] redirect %h -> %h", rip_q, redirect_rip);
  end
`else
`endif
endmodule
